// File: rtl/raw_record_if.sv
// Board-side pin bundle of raw_record: serial audio inputs plus UART/LED outputs.
interface raw_record_if;
  logic       sck;
  logic       ws;
  logic       sd;
  logic       uart_tx;
  logic [7:0] leds;

  // Pin-driving side (board stimulus / logger)
  modport master (output sck, output ws, output sd, input uart_tx, input leds);
  // Recorder side
  modport slave  (input sck, input ws, input sd, output uart_tx, output leds);
endinterface

// File: rtl/raw_record.sv
// raw_record: captures a left-justified 3-wire audio stream into 16-bit channel
// words, buffers them in a small FIFO and streams them out over an 8N1 UART.
// Optional feature: define RAWREC_CHAN_TAG_EN to prefix each word with a
// channel tag byte (8'hA0 | chan), giving 3 bytes per word instead of 2.
module raw_record #(
  parameter logic [23:0] STARTUP_CYCLES = 24'hFFFFFF,
  parameter int unsigned BAUD_DIV       = 8,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic         clk,
  input  logic         rst,
  raw_record_if.slave  bus
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef struct packed {
    logic              chan;
    logic [WORD_W-1:0] data;
  } word_t;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // ---------------- input synchronizers ----------------
  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_ws_s1, r_ws_s2, r_sd_s1, r_sd_s2;
  logic w_sck_rise;

  // Two-flop synchronizers; sck gets one extra flop for rise detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_s1 <= 1'b0; r_sck_s2 <= 1'b0; r_sck_d <= 1'b0;
      r_ws_s1  <= 1'b0; r_ws_s2  <= 1'b0;
      r_sd_s1  <= 1'b0; r_sd_s2  <= 1'b0;
    end else begin
      r_sck_s1 <= bus.sck; r_sck_s2 <= r_sck_s1; r_sck_d <= r_sck_s2;
      r_ws_s1  <= bus.ws;  r_ws_s2  <= r_ws_s1;
      r_sd_s1  <= bus.sd;  r_sd_s2  <= r_sd_s1;
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_d;

  // ---------------- startup delay ----------------
  logic [23:0] r_delay, w_delay_nxt;
  logic        r_armed;

  assign w_delay_nxt = (r_delay != 24'd0) ? r_delay - 24'd1 : r_delay;

  // Count down after reset; capture is armed once the counter reaches zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_delay <= STARTUP_CYCLES;
      r_armed <= 1'b0;
    end else begin
      r_delay <= w_delay_nxt;
      r_armed <= (w_delay_nxt == 24'd0);
    end
  end

  // ---------------- serial capture ----------------
  logic              r_prev_ch;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_shreg;
  logic              w_ws_change, w_push;
  word_t             w_push_word;

  assign w_ws_change = (r_ws_s2 != r_prev_ch);
  assign w_push      = w_sck_rise & r_armed & w_ws_change & (r_bit_cnt == CNT_W'(WORD_W));
  assign w_push_word = word_t'({r_prev_ch, r_shreg});

  // Shift bits into the slot word; a WS change closes the slot and starts a new one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_ch <= 1'b1;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else if (w_sck_rise && r_armed) begin
      if (w_ws_change) begin
        r_shreg   <= {15'b0, r_sd_s2};
        r_bit_cnt <= CNT_W'(1);
        r_prev_ch <= r_ws_s2;
      end else if (r_bit_cnt < CNT_W'(WORD_W)) begin
        r_shreg   <= {r_shreg[WORD_W-2:0], r_sd_s2};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------- word FIFO ----------------
  word_t       r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        r_ovf, r_toggle;
  logic        w_empty, w_full, w_pop, w_push_ok;
  word_t       w_head;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= w_push_word;
  end

  // Pointers, sticky overflow flag and per-word activity toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
        r_toggle <= ~r_toggle;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (w_push && !w_push_ok) r_ovf <= 1'b1;
    end
  end

  // ---------------- UART transmitter ----------------
  uart_state_e       r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [7:0]        r_byte, w_byte_nxt;
  logic [15:0]       r_pend, w_pend_nxt;
  logic [1:0]        r_pend_cnt, w_pend_cnt_nxt;
  logic              r_tx, w_tx_nxt, w_baud_end;

  assign w_baud_end = (r_baud == BAUD_W'(BAUD_DIV - 1));

`ifndef RAWREC_CHAN_TAG_EN
  logic w_unused_chan;
  assign w_unused_chan = w_head.chan;
`endif

  // UART state register and registered line output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_pend     <= '0;
      r_pend_cnt <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit      <= w_bit_nxt;
      r_byte     <= w_byte_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_pend_cnt_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // Next-state logic: pop a word when idle, then shift out its bytes back to back
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = r_baud;
    w_bit_nxt      = r_bit;
    w_byte_nxt     = r_byte;
    w_pend_nxt     = r_pend;
    w_pend_cnt_nxt = r_pend_cnt;
    w_pop          = 1'b0;
    w_tx_nxt       = 1'b1;

    if (r_state != S_IDLE) w_baud_nxt = w_baud_end ? '0 : r_baud + BAUD_W'(1);

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_baud_nxt  = '0;
`ifdef RAWREC_CHAN_TAG_EN
          w_byte_nxt     = 8'hA0 | {7'b0, w_head.chan};
          w_pend_nxt     = w_head.data;
          w_pend_cnt_nxt = 2'd2;
`else
          w_byte_nxt     = w_head.data[15:8];
          w_pend_nxt     = {w_head.data[7:0], 8'h00};
          w_pend_cnt_nxt = 2'd1;
`endif
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          if (r_pend_cnt != 2'd0) begin
            w_state_nxt    = S_START;
            w_byte_nxt     = r_pend[15:8];
            w_pend_nxt     = {r_pend[7:0], 8'h00};
            w_pend_cnt_nxt = r_pend_cnt - 2'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_byte_nxt[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign bus.uart_tx = r_tx;
  assign bus.leds    = {5'b0, r_toggle, r_ovf, r_armed};

endmodule

// File: tb/tb_raw_record.sv
// Bench for raw_record: a fast-UART instance for framing/word tests and a
// slow-UART instance for FIFO overflow and mid-byte reset.
module tb_raw_record;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_f, rst_s, sck, ws, sd, sel;

  raw_record_if bus_f ();
  raw_record_if bus_s ();

  assign bus_f.sck = sck; assign bus_f.ws = ws; assign bus_f.sd = sd;
  assign bus_s.sck = sck; assign bus_s.ws = ws; assign bus_s.sd = sd;

  raw_record #(.STARTUP_CYCLES(24'd4), .BAUD_DIV(8), .FIFO_DEPTH(16)) dut_f (
    .clk(clk), .rst(rst_f), .bus(bus_f));
  raw_record #(.STARTUP_CYCLES(24'd4), .BAUD_DIV(100), .FIFO_DEPTH(16)) dut_s (
    .clk(clk), .rst(rst_s), .bus(bus_s));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  logic       rx_ok[$];
  logic [7:0] exp_q[$];

  logic mon_tx, mon_rst;
  assign mon_tx  = sel ? bus_s.uart_tx : bus_f.uart_tx;
  assign mon_rst = sel ? rst_s : rst_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic w, input logic d);
    ws = w; sd = d; sck = 1'b0;
    clks(2);
    sck = 1'b1;
    clks(2);
    sck = 1'b0;
  endtask

  task automatic send_slot(input logic w, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w, bits[i]);
  endtask

  task automatic add_word(input logic ch, input logic [15:0] d);
`ifdef RAWREC_CHAN_TAG_EN
    exp_q.push_back(8'hA0 | {7'b0, ch});
`endif
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic wait_bytes(input int n, input int bound, input int settle);
    int t = 0;
    while (rx_q.size() < n && t < bound) begin
      @(posedge clk);
      t++;
    end
    clks(settle);
  endtask

  task automatic compare_rx(input string tag);
    chk($sformatf("%s_count", tag), 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s_frame%0d", tag, i), 32'(rx_ok[i]), 32'd1);
    end
    rx_q.delete(); rx_ok.delete(); exp_q.delete();
  endtask

  // UART monitor: checks every clock of a frame against its expected level
  initial begin
    int         bd;
    int         bi;
    logic [7:0] b;
    logic       ok, aborted;
    forever begin
      @(posedge clk); #1;
      if (!mon_rst && mon_tx === 1'b0) begin
        bd = sel ? 100 : 8;
        b = '0; ok = 1'b1; aborted = 1'b0;
        for (int k = 1; k < 10 * bd; k++) begin
          @(posedge clk); #1;
          if (mon_rst) begin aborted = 1'b1; break; end
          bi = k / bd;
          if (bi == 0) begin
            if (mon_tx !== 1'b0) ok = 1'b0;
          end else if (bi == 9) begin
            if (mon_tx !== 1'b1) ok = 1'b0;
          end else if (k % bd == 0) begin
            b[bi-1] = mon_tx;
          end else if (mon_tx !== b[bi-1]) begin
            ok = 1'b0;
          end
        end
        if (!aborted) begin
          rx_q.push_back(b);
          rx_ok.push_back(ok);
        end
      end
    end
  end

  // Global time bound
  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        w;
    logic [31:0] bits;
    int          nbits;
    logic        emit;
    logic        chan;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[9];
  logic exp_tog;

  initial begin
    // slot to send, and the word the start of this slot must release
    vecs[0] = '{1'b0, 32'h0000_0001, 16, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 32'h0000_1234, 16, 1'b1, 1'b0, 16'h0001};
    vecs[2] = '{1'b0, 32'h0000_8001, 16, 1'b1, 1'b1, 16'h1234};
    vecs[3] = '{1'b1, 32'h0000_0003, 16, 1'b1, 1'b0, 16'h8001};
    vecs[4] = '{1'b0, 32'h00AB_CD5A, 24, 1'b1, 1'b1, 16'h0003};
    vecs[5] = '{1'b1, 32'h0000_03FF, 10, 1'b1, 1'b0, 16'hABCD};
    vecs[6] = '{1'b0, 32'h0000_BEEF, 16, 1'b0, 1'b0, 16'h0000};
    vecs[7] = '{1'b1, 32'h0000_0F0F, 16, 1'b1, 1'b0, 16'hBEEF};
    vecs[8] = '{1'b0, 32'h0000_0000, 1,  1'b1, 1'b1, 16'h0F0F};

    rst_f = 1'b1; rst_s = 1'b1; sck = 1'b0; ws = 1'b1; sd = 1'b0; sel = 1'b0;
    exp_tog = 1'b0;

    // Reset state and arming delay
    clks(3);
    chk("rst_tx", 32'(bus_f.uart_tx), 32'd1);
    chk("rst_leds", 32'(bus_f.leds), 32'd0);
    rst_f = 1'b0;
    clks(3);
    chk("armed_early", 32'(bus_f.leds[0]), 32'd0);
    clks(1);
    chk("armed_on_time", 32'(bus_f.leds[0]), 32'd1);
    chk("idle_tx", 32'(bus_f.uart_tx), 32'd1);

    // Table-driven slots on the fast instance
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].emit) add_word(vecs[i].chan, vecs[i].data);
      send_slot(vecs[i].w, vecs[i].bits, vecs[i].nbits);
      wait_bytes(exp_q.size(), 800, 120);
      compare_rx($sformatf("vec%0d", i));
      exp_tog = exp_tog ^ vecs[i].emit;
      chk($sformatf("vec%0d_toggle", i), 32'(bus_f.leds[2]), 32'(exp_tog));
      chk($sformatf("vec%0d_ovf", i), 32'(bus_f.leds[1]), 32'd0);
    end

    // FIFO overflow on the slow instance: 20 words, 17 survive
    sel = 1'b1;
    rst_s = 1'b0;
    clks(10);
    chk("slow_armed", 32'(bus_s.leds[0]), 32'd1);
    for (int j = 0; j < 21; j++) send_slot(1'(j % 2), 32'h1000 + 32'(j), 16);
    for (int j = 0; j < 17; j++) add_word(1'(j % 2), 16'(16'h1000 + j));
    chk("ovf_set", 32'(bus_s.leds[1]), 32'd1);
    chk("ovf_toggle", 32'(bus_s.leds[2]), 32'd1);
    wait_bytes(exp_q.size(), exp_q.size() * 1100 + 500, 1200);
    compare_rx("ovf");
    chk("ovf_sticky", 32'(bus_s.leds[1]), 32'd1);

    // Reset in the middle of a byte
    send_slot(1'b1, 32'h0000_5555, 16);
    send_bit(1'b0, 1'b0);
    clks(300);
    chk("midbyte_busy", 32'(bus_s.uart_tx === 1'b0 || bus_s.uart_tx === 1'b1), 32'd1);
    rst_s = 1'b1;
    clks(1);
    chk("midbyte_rst_tx", 32'(bus_s.uart_tx), 32'd1);
    chk("midbyte_rst_leds", 32'(bus_s.leds), 32'd0);
    rst_s = 1'b0;
    clks(3);
    chk("rearm_early", 32'(bus_s.leds[0]), 32'd0);
    clks(1);
    chk("rearm_on_time", 32'(bus_s.leds[0]), 32'd1);
    clks(3000);
    chk("flushed_bytes", 32'(rx_q.size()), 32'd0);
    chk("flushed_tx", 32'(bus_s.uart_tx), 32'd1);
    chk("flushed_ovf", 32'(bus_s.leds[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
